dut_regfile: RTL and testbench

Command-driven 16-entry register file that sits directly downstream of the `dut_if` bus and consumes the `cmd`/`adr`/`data` triple through the slave modport.
- Each cycle it samples one command and executes it: write, read, increment, decrement, or a multi-cycle clear/fill sweep.
- It returns read data one cycle later.
- It reports busy, dropped-command and illegal-command status for the bench and the coverage collectors.

---
 rtl/dut_regfile_pkg.sv | 32 +++
 rtl/dut_regfile_if.sv | 12 +
 rtl/dut_regfile_mem.sv | 29 ++
 rtl/dut_regfile.sv | 116 +++++++++++
 tb/tb_dut_regfile.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/dut_regfile_pkg.sv
// Shared command/state encodings and sizing helpers for the command-driven register file.
package dut_regfile_pkg;

    typedef enum logic [3:0] {
        CMD_NOP  = 4'd0,
        CMD_WR   = 4'd1,
        CMD_RD   = 4'd2,
        CMD_INC  = 4'd3,
        CMD_DEC  = 4'd4,
        CMD_CLR  = 4'd5,
        CMD_FILL = 4'd6
    } cmd_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

    localparam int unsigned DEFAULT_ADR_W = 4;

    function automatic int unsigned num_entries(input int unsigned adr_w);
        return 32'd1 << adr_w;
    endfunction

    localparam int unsigned NUM_ENTRIES = num_entries(DEFAULT_ADR_W);

    // Codes 7..15 are reserved and counted as errors when seen in IDLE.
    function automatic logic is_legal(input logic [3:0] code);
        return code <= 4'd6;
    endfunction

endpackage

// File: rtl/dut_regfile_if.sv
// Command bus carrying the cmd/adr/data triple from the driver to the register file.
interface dut_if #(
    parameter int unsigned ADR_W  = 4,
    parameter int unsigned DATA_W = 4
);
    logic [3:0]        cmd;
    logic [ADR_W-1:0]  adr;
    logic [DATA_W-1:0] data;

    modport master (output cmd, adr, data);
    modport slave  (input  cmd, adr, data);
endinterface

// File: rtl/dut_regfile_mem.sv
// Storage array: one write port, one combinational read port, asynchronous clear.
module dut_regfile_mem
    import dut_regfile_pkg::*;
#(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADR_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [num_entries(ADR_W)];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '{default: '0};
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dut_regfile.sv
// Register file top: command FSM, sweep pointer, registered read result and saturating status counters.
module dut_regfile
    import dut_regfile_pkg::*;
#(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADR_W  = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    dut_if.slave              bus,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              busy,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    state_e            state;
    logic [ADR_W-1:0]  ptr;
    logic [DATA_W-1:0] sweep_val;

    logic              we;
    logic [ADR_W-1:0]  waddr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rd_val;

    dut_regfile_mem #(
        .DATA_W (DATA_W),
        .ADR_W  (ADR_W)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (bus.adr),
        .rdata (rd_val)
    );

    // Write port mux; wdata doubles as the INC/DEC result returned on rdata.
    always_comb begin
        we    = 1'b0;
        waddr = bus.adr;
        wdata = bus.data;
        if (state == SWEEP) begin
            we    = 1'b1;
            waddr = ptr;
            wdata = sweep_val;
        end else begin
            case (cmd_e'(bus.cmd))
                CMD_WR:  we = 1'b1;
                CMD_INC: begin
                    we    = 1'b1;
                    wdata = rd_val + DATA_W'(1);
                end
                CMD_DEC: begin
                    we    = 1'b1;
                    wdata = rd_val - DATA_W'(1);
                end
                default: we = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            sweep_val <= '0;
            rdata     <= '0;
            rvalid    <= 1'b0;
            busy      <= 1'b0;
            drop_cnt  <= '0;
            err_cnt   <= '0;
        end else begin
            rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!is_legal(bus.cmd)) begin
                        if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
                    end
                    case (cmd_e'(bus.cmd))
                        CMD_RD: begin
                            rdata  <= rd_val;
                            rvalid <= 1'b1;
                        end
                        CMD_INC, CMD_DEC: begin
                            rdata  <= wdata;
                            rvalid <= 1'b1;
                        end
                        CMD_CLR, CMD_FILL: begin
                            sweep_val <= (cmd_e'(bus.cmd) == CMD_FILL) ? bus.data : '0;
                            ptr       <= '0;
                            busy      <= 1'b1;
                            state     <= SWEEP;
                        end
                        default: ;
                    endcase
                end
                SWEEP: begin
                    if (bus.cmd != CMD_NOP) begin
                        if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
                    end
                    ptr <= ptr + ADR_W'(1);
                    if (&ptr) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dut_regfile.sv
// Directed and randomized checks of dut_regfile against a behavioural model of the register file.
module tb_dut_regfile;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] rdata;
    logic       rvalid;
    logic       busy;
    logic [7:0] drop_cnt;
    logic [7:0] err_cnt;

    int total = 0;
    int bad   = 0;

    dut_if #(.ADR_W(4), .DATA_W(4)) bus ();

    dut_regfile #(.DATA_W(4), .ADR_W(4), .CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .busy     (busy),
        .drop_cnt (drop_cnt),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: plain array plus a count of sweep writes still pending.
    int m_mem [16];
    int m_sweep_left;
    int m_sweep_val;
    int m_drop;
    int m_err;
    int m_rvalid;
    int m_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 0;
        m_sweep_left = 0;
        m_sweep_val  = 0;
        m_drop       = 0;
        m_err        = 0;
        m_rvalid     = 0;
        m_rdata      = 0;
    endtask

    task automatic model_step(input int c, input int a, input int d);
        m_rvalid = 0;
        if (m_sweep_left > 0) begin
            m_mem[16 - m_sweep_left] = m_sweep_val;
            m_sweep_left--;
            if (c != 0) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        end else begin
            case (c)
                0: ;
                1: m_mem[a] = d;
                2: begin m_rvalid = 1; m_rdata = m_mem[a]; end
                3: begin m_mem[a] = (m_mem[a] + 1) % 16; m_rvalid = 1; m_rdata = m_mem[a]; end
                4: begin m_mem[a] = (m_mem[a] + 15) % 16; m_rvalid = 1; m_rdata = m_mem[a]; end
                5: begin m_sweep_left = 16; m_sweep_val = 0; end
                6: begin m_sweep_left = 16; m_sweep_val = d; end
                default: m_err = (m_err < 255) ? m_err + 1 : 255;
            endcase
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".rvalid"}, 32'(rvalid), 32'(m_rvalid));
        if (m_rvalid != 0) check({tag, ".rdata"}, 32'(rdata), 32'(m_rdata));
        check({tag, ".busy"}, 32'(busy), 32'(m_sweep_left > 0));
        check({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(m_drop));
        check({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_err));
    endtask

    // Drive one command for one clock edge, advance the model, then compare just after the edge.
    task automatic do_cmd(input int c, input int a, input int d, input string tag);
        bus.cmd  = 4'(c);
        bus.adr  = 4'(a);
        bus.data = 4'(d);
        @(posedge clk);
        model_step(c, a, d);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("reset");
        check("reset.rdata", 32'(rdata), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < 16; i++) do_cmd(2, i, 0, tag);
    endtask

    initial begin
        bus.cmd  = '0;
        bus.adr  = '0;
        bus.data = '0;
        #2;
        do_reset();
        @(posedge clk); #1;

        // Basic write/read, every other entry still zero.
        do_cmd(1, 3, 9, "wr3");
        do_cmd(2, 3, 0, "rd3");
        check("rd3.value", 32'(rdata), 32'd9);
        read_all("scan1");

        // Increment/decrement wrap.
        do_cmd(1, 5, 15, "wr5");
        do_cmd(3, 5, 0, "inc5");
        check("inc5.wrap", 32'(rdata), 32'd0);
        do_cmd(4, 5, 0, "dec5");
        check("dec5.wrap", 32'(rdata), 32'd15);
        do_cmd(2, 5, 0, "rd5");

        // FILL with a dropped write at E3 and data changed mid-sweep.
        do_cmd(6, 0, 7, "fill7.E0");
        for (int e = 1; e <= 16; e++) begin
            if (e == 3) do_cmd(1, 0, 1, "fill7.drop");
            else        do_cmd(0, 0, 12, "fill7.sweep");
        end
        do_cmd(2, 0, 0, "fill7.E17");
        check("fill7.rd0", 32'(rdata), 32'd7);
        check("fill7.drops", 32'(drop_cnt), 32'd1);
        read_all("fill7.scan");

        // Illegal codes in IDLE vs. during a CLR sweep, then saturation.
        do_reset();
        for (int i = 0; i < 3; i++) do_cmd(9, 0, 0, "illegal.idle");
        do_cmd(5, 0, 0, "clr.E0");
        do_cmd(9, 0, 0, "illegal.sweep");
        for (int e = 2; e <= 16; e++) do_cmd(0, 0, 0, "clr.sweep");
        check("illegal.err", 32'(err_cnt), 32'd3);
        check("illegal.drop", 32'(drop_cnt), 32'd1);
        for (int i = 0; i < 300; i++) do_cmd(7 + (i % 9), i % 16, 0, "illegal.sat");
        check("err.sat", 32'(err_cnt), 32'd255);

        // Reset mid-FILL: everything clears at once.
        do_cmd(6, 0, 4, "fill4.E0");
        for (int e = 1; e <= 8; e++) do_cmd(0, 0, 4, "fill4.sweep");
        rst_n = 1'b0;
        model_reset();
        #1;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.rvalid", 32'(rvalid), 32'd0);
        check("abort.err", 32'(err_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_cmd(2, 0, 0, "abort.rd0");
        check("abort.rd0.rvalid", 32'(rvalid), 32'd1);
        read_all("abort.scan");

        // Back-to-back reads after FILL 2 give continuous rvalid.
        do_cmd(6, 0, 2, "fill2.E0");
        for (int e = 1; e <= 16; e++) do_cmd(0, 0, 0, "fill2.sweep");
        for (int i = 0; i < 16; i++) begin
            do_cmd(2, i, 0, "b2b");
            check("b2b.rvalid", 32'(rvalid), 32'd1);
            check("b2b.rdata", 32'(rdata), 32'd2);
        end

        // Randomized traffic, sweeps kept rare so most commands reach IDLE.
        for (int n = 0; n < 600; n++) begin
            int r, c;
            r = int'($urandom_range(0, 99));
            if      (r < 20) c = 1;
            else if (r < 45) c = 2;
            else if (r < 60) c = 3;
            else if (r < 75) c = 4;
            else if (r < 85) c = 0;
            else if (r < 88) c = 5;
            else if (r < 91) c = 6;
            else             c = int'($urandom_range(7, 15));
            do_cmd(c, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), "rand");
        end
        for (int e = 0; e < 17; e++) do_cmd(0, 0, 0, "rand.drain");
        read_all("rand.scan");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL timeout observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
